// File: rtl/vc_input_buffer_pkg.sv
// Shared encodings and helpers for the VC input buffer: flit types, write-side
// packet states and a constant ceiling-log2 used for pointer/count widths.
package vc_input_buffer_pkg;

  localparam int unsigned FlitTypeW = 2;

  typedef enum logic [FlitTypeW-1:0] {
    FlitBody   = 2'b00,
    FlitTail   = 2'b01,
    FlitHead   = 2'b10,
    FlitSingle = 2'b11
  } flit_type_e;

  typedef enum logic {
    StIdle  = 1'b0,
    StInPkt = 1'b1
  } wr_state_e;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-VC synchronous FIFO with registered occupancy. The owner guarantees no
// push into a full FIFO unless it pops in the same cycle, and no pop when empty.
module vc_fifo
  import vc_input_buffer_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   rd_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [log2(Depth):0]   count_o
);

  localparam int unsigned PtrW = log2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_i) rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({wr_i, rd_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/vc_input_buffer.sv
// Router input port: one FIFO per VC, per-VC packet framing check, request
// generation and registered pop toward the crossbar with one-hot credit return.
// Define VC_BUFF_OCCUPANCY_EN to expose per-VC counts on occupancy_out.
module vc_input_buffer
  import vc_input_buffer_pkg::*;
#(
  parameter int unsigned V          = 4,
  parameter int unsigned BUFF_DEPTH = 4,
  parameter int unsigned FLIT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLIT_WIDTH-1:0] flit_in,
  input  logic                  flit_in_we,
  input  logic [V-1:0]          vc_num_in,
  input  logic [V-1:0]          ds_credit_avail,
  input  logic [V-1:0]          grant_in,
  output logic [V-1:0]          req_out,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  flit_out_valid,
  output logic [V-1:0]          credit_out,
  output logic [V-1:0]          empty_out,
  output logic [V-1:0]          full_out,
  output logic                  err_out
`ifdef VC_BUFF_OCCUPANCY_EN
  ,
  output logic [V*(log2(BUFF_DEPTH)+1)-1:0] occupancy_out
`endif
);

  localparam int unsigned CntW = log2(BUFF_DEPTH) + 1;

  logic [V-1:0]          fifo_wr, fifo_rd, fifo_empty, fifo_full;
  logic [FLIT_WIDTH-1:0] fifo_rdata [V];
  logic [CntW-1:0]       fifo_count [V];

  wr_state_e             state_q [V];
  wr_state_e             state_d [V];
  flit_type_e            flit_type;
  logic                  wr_onehot, gnt_legal;
  logic                  err_q, err_d;
  logic [FLIT_WIDTH-1:0] pop_data;
  logic [FLIT_WIDTH-1:0] flit_out_q, flit_out_d;
  logic                  valid_q, valid_d;
  logic [V-1:0]          credit_q, credit_d;

  for (genvar g = 0; g < V; g++) begin : g_vc
    vc_fifo #(
      .Depth (BUFF_DEPTH),
      .Width (FLIT_WIDTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (fifo_wr[g]),
      .wdata_i (flit_in),
      .rd_i    (fifo_rd[g]),
      .rdata_o (fifo_rdata[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g]),
      .count_o (fifo_count[g])
    );
  end

  assign req_out = ~fifo_empty & ds_credit_avail;

  always_comb begin
    wr_onehot = $onehot(vc_num_in);
    gnt_legal = $onehot(grant_in) && ((grant_in & ~req_out) == '0);
    fifo_rd   = gnt_legal ? grant_in : '0;
    flit_type = flit_type_e'(flit_in[FLIT_WIDTH-1 -: FlitTypeW]);
    fifo_wr   = '0;
    pop_data  = '0;
    err_d     = err_q;

    if (flit_in_we && !wr_onehot) err_d = 1'b1;
    if ((grant_in != '0) && !gnt_legal) err_d = 1'b1;

    for (int unsigned v = 0; v < V; v++) begin
      state_d[v] = state_q[v];
      // A full VC still accepts a write when it is popped in the same cycle.
      fifo_wr[v] = flit_in_we & wr_onehot & vc_num_in[v] & (~fifo_full[v] | fifo_rd[v]);
      if (flit_in_we && wr_onehot && vc_num_in[v] && fifo_full[v] && !fifo_rd[v]) begin
        err_d = 1'b1;
      end
      if (fifo_wr[v]) begin
        unique case (state_q[v])
          StIdle: begin
            if (flit_type == FlitHead) state_d[v] = StInPkt;
            else if (flit_type != FlitSingle) err_d = 1'b1;
          end
          StInPkt: begin
            if (flit_type == FlitTail) state_d[v] = StIdle;
            else if (flit_type != FlitBody) err_d = 1'b1;
          end
          default: state_d[v] = state_q[v];
        endcase
      end
      pop_data = pop_data | (fifo_rdata[v] & {FLIT_WIDTH{fifo_rd[v]}});
    end

    valid_d    = |fifo_rd;
    credit_d   = fifo_rd;
    flit_out_d = valid_d ? pop_data : flit_out_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned v = 0; v < V; v++) state_q[v] <= StIdle;
      err_q      <= 1'b0;
      flit_out_q <= '0;
      valid_q    <= 1'b0;
      credit_q   <= '0;
    end else begin
      for (int unsigned v = 0; v < V; v++) state_q[v] <= state_d[v];
      err_q      <= err_d;
      flit_out_q <= flit_out_d;
      valid_q    <= valid_d;
      credit_q   <= credit_d;
    end
  end

  assign flit_out       = flit_out_q;
  assign flit_out_valid = valid_q;
  assign credit_out     = credit_q;
  assign empty_out      = fifo_empty;
  assign full_out       = fifo_full;
  assign err_out        = err_q;

`ifdef VC_BUFF_OCCUPANCY_EN
  for (genvar g = 0; g < V; g++) begin : g_occ
    assign occupancy_out[g*CntW +: CntW] = fifo_count[g];
  end
`else
  logic [V*CntW-1:0] unused_count;
  for (genvar g = 0; g < V; g++) begin : g_occ
    assign unused_count[g*CntW +: CntW] = fifo_count[g];
  end
`endif

endmodule

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
- Input-port buffer of a VC-based mesh router. Holds one FIFO per virtual channel.
- Raises one request bit per VC that is ready to send. This request vector drives the round-robin switch arbiter directly.
- Consumes the arbiter's one-hot grant to pop one flit, registers it toward the crossbar, and returns a one-hot credit upstream.

Parameters:
- V, 4, number of virtual channels; arbiter width; power of two, ≥2.
- BUFF_DEPTH, 4, flits per VC FIFO; power of two, ≥2.
- FLIT_WIDTH, 32, flit width; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] carry the flit type.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- flit_in  in  FLIT_WIDTH  incoming flit
- flit_in_we  in  1  write strobe for flit_in
- vc_num_in  in  V  one-hot target VC of flit_in
- ds_credit_avail  in  V  downstream VC has at least one credit
- grant_in  in  V  one-hot grant from the switch arbiter
- req_out  out  V  per-VC request to the arbiter
- flit_out  out  FLIT_WIDTH  registered popped flit
- flit_out_valid  out  1  flit_out valid
- credit_out  out  V  one-hot credit pulse to the upstream router
- empty_out  out  V  per-VC FIFO empty
- full_out  out  V  per-VC FIFO full
- err_out  out  1  sticky protocol/overflow error

Behaviour:
- Reset values:
  - All FIFO pointers are cleared.
  - empty_out = all 1; full_out = 0.
  - req_out = 0; flit_out = 0; flit_out_valid = 0; credit_out = 0; err_out = 0.
  - All write-side FSMs are in IDLE.
- Reset is asynchronous and may occur mid-packet. Buffered flits are discarded and no credits are returned for them.
- Write path:
  - A write occurs when flit_in_we=1 and vc_num_in is one-hot. The flit is stored at the tail of that VC in the next cycle.
  - If vc_num_in is not one-hot while flit_in_we=1, no write occurs and err_out is set.
  - A write to a full VC with no simultaneous pop of that VC is dropped and sets err_out.
  - There is no write-to-read bypass. A flit written into an empty VC can first be requested one cycle later.
- Per-VC write-side FSM:
  - IDLE: a HEAD flit moves the FSM to IN_PKT. A SINGLE flit keeps it in IDLE. BODY or TAIL sets err_out; the flit is still stored.
  - IN_PKT: BODY keeps IN_PKT. TAIL returns to IDLE. HEAD or SINGLE sets err_out and stays in IN_PKT.
- Request (combinational): req_out[v] = ~empty[v] & ds_credit_avail[v].
- Pop:
  - grant_in must be one-hot and a subset of req_out. When it is, the head flit of the granted VC is popped the same cycle.
  - On the next edge, flit_out takes that flit and flit_out_valid=1.
  - On that same edge, credit_out takes grant_in as a 1-cycle pulse. Pop-to-output latency is 1 cycle.
- An illegal grant is ignored (no pop) and sets err_out. Illegal means not one-hot, or targeting a VC with req_out=0.
- When there is no grant, flit_out holds its value and flit_out_valid=0.
- Simultaneous read and write on the same VC:
  - Both take effect and the occupancy is unchanged.
  - This is legal even when the VC is full.
  - It is also legal when the VC holds exactly 1 flit: it pops the old flit and stores the new one.
- Pointer and count widths:
  - Pointers are log2(BUFF_DEPTH) bits and wrap naturally.
  - Occupancy is log2(BUFF_DEPTH)+1 bits.
  - full = (count == BUFF_DEPTH); empty = (count == 0).
- err_out is sticky and is cleared only by reset.

Optional Feature:
- Macro: VC_BUFF_OCCUPANCY_EN.
- When defined, an extra output port occupancy_out (V*(log2(BUFF_DEPTH)+1)) is added. It presents the per-VC count, with VC0 in the LSBs. The value is registered and updated on the same edge as the FIFO.
- When undefined, the port does not exist and the counts are internal only. All other behaviour is identical.

Decomposition:
- Shared package/define file holds:
  - flit type encodings: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE=2'b11;
  - FSM state encodings: IDLE=1'b0, IN_PKT=1'b1;
  - the existing LOG2 function macro.
- One sub-module: vc_fifo, a single-VC synchronous FIFO with wr/rd/full/empty/count. It is instantiated V times with generate.
- The wrapper holds the FSMs, the request/grant logic, the output register and the credit register.

Test Plan:
- Write HEAD/BODY/TAIL (3 flits) to VC2 with ds_credit_avail=4'b1111.
  - Required: req_out=4'b0100 from the cycle after the first write.
  - Grant 4'b0100 three times. Required: flit_out follows the 3 flits in order with 1-cycle latency, credit_out=4'b0100 pulses 3 times, and empty_out[2]=1 at the end.
- Fill VC0 with 4 flits.
  - Required: full_out[0]=1.
  - Write a 5th flit with no grant. Required: it is dropped, err_out=1, and the content is unchanged on pop.
- With VC1 full, write to and grant VC1 in the same cycle.
  - Required: count stays 4, full_out[1] stays 1, and credit_out=4'b0010 next cycle.
- With VC3 non-empty and ds_credit_avail[3]=0: required req_out[3]=0.
  - Raise ds_credit_avail[3]. Required: req_out[3]=1 combinationally.
  - Apply grant_in=4'b1000 while req_out[3]=0. Required: no pop and err_out=1.
- Write BODY to an IDLE VC. Required: err_out=1.
  - Then write HEAD followed by HEAD. Required: the second HEAD sets err_out and the FSM stays IN_PKT.
- Assert reset mid-packet with VC0 holding 2 flits.
  - Required: all outputs return to their reset values asynchronously, and no credit_out pulse is emitted for the discarded flits.
